// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - coin codes shared by the sensor frontend, the coin FSM and their benches
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_A    = 2'b01;
    localparam logic [1:0] COIN_B    = 2'b10;
    localparam logic [1:0] COIN_C    = 2'b11;

    // grant is one-hot {c,b,a}; an empty grant maps to no coin
    function automatic logic [1:0] coin_code(input logic [2:0] grant);
        logic [1:0] code;
        code = COIN_NONE;
        if (grant[0]) begin
            code = COIN_A;
        end else if (grant[1]) begin
            code = COIN_B;
        end else if (grant[2]) begin
            code = COIN_C;
        end
        return code;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - synchroniser, debouncer, rising-edge event and jam detect for one sensor line
module coin_debounce #(
    parameter int DEBOUNCE   = 4,
    parameter int JAM_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic evt,
    output logic jam
);

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int JW = (JAM_CYCLES > 1) ? $clog2(JAM_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [JW-1:0] jam_cnt_q, jam_cnt_d;
    logic          jam_q, jam_d;
    logic          evt_q, evt_d;

    always_comb begin
        sync1_d   = raw;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        db_cnt_d  = '0;
        jam_cnt_d = '0;
        jam_d     = 1'b0;
        evt_d     = 1'b0;

        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // the jam counter and flag drop on the same edge the stable level falls
        if (stable_q && stable_d) begin
            jam_cnt_d = (jam_cnt_q == JAM_LAST) ? jam_cnt_q : jam_cnt_q + 1'b1;
            jam_d     = jam_q || (jam_cnt_d == JAM_LAST);
        end

        evt_d = stable_d && !stable_q && !jam_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            jam_cnt_q <= '0;
            jam_q     <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            jam_cnt_q <= jam_cnt_d;
            jam_q     <= jam_d;
            evt_q     <= evt_d;
        end
    end

    assign evt = evt_q;
    assign jam = jam_q;

endmodule

// File: rtl/coin_sensor_frontend.sv
// rtl/coin_sensor_frontend.sv - three debounced coin sensors serialised onto the (i,j) coin code
module coin_sensor_frontend
    import coin_pkg::*;
#(
    parameter int DEBOUNCE   = 4,
    parameter int JAM_CYCLES = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sens_a,
    input  logic             sens_b,
    input  logic             sens_c,
    input  logic             accept_en,
    output logic             i,
    output logic             j,
    output logic             reject,
    output logic [2:0]       jam,
    output logic [CNT_W-1:0] coin_count
);

    logic [2:0]       evt;
    logic [2:0]       raw;
    logic [2:0]       grant;
    logic [2:0]       pending_q, pending_d;
    logic [1:0]       code_q, code_d;
    logic             reject_q, reject_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign raw = {sens_c, sens_b, sens_a};

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        coin_debounce #(
            .DEBOUNCE  (DEBOUNCE),
            .JAM_CYCLES(JAM_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[ch]),
            .evt  (evt[ch]),
            .jam  (jam[ch])
        );
    end

    always_comb begin
        grant = 3'b000;
        if (pending_q[0]) begin
            grant = 3'b001;
        end else if (pending_q[1]) begin
            grant = 3'b010;
        end else if (pending_q[2]) begin
            grant = 3'b100;
        end

        // a fresh event re-arms its bit even if that bit is being granted this cycle
        pending_d = (pending_q & ~grant) | (accept_en ? evt : 3'b000);
        code_d    = coin_code(grant);
        reject_d  = !accept_en && (|evt);

        count_d = count_q;
        if ((|grant) && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 3'b000;
            code_q    <= COIN_NONE;
            reject_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            reject_q  <= reject_d;
            count_q   <= count_d;
        end
    end

    assign i          = code_q[1];
    assign j          = code_q[0];
    assign reject     = reject_q;
    assign coin_count = count_q;

endmodule
